// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nes_pkg;

  // Number of serial button bits in one frame.
  localparam int NES_BITS = 8;

  // Button positions in the parallel button word and in the serial order.
  typedef enum logic [2:0] {
    BTN_A    = 3'd0,
    BTN_B    = 3'd1,
    BTN_SEL  = 3'd2,
    BTN_STRT = 3'd3,
    BTN_UP   = 3'd4,
    BTN_DN   = 3'd5,
    BTN_L    = 3'd6,
    BTN_R    = 3'd7
  } nes_btn_e;

  // Responder frame state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } nes_state_e;

endpackage

// File: rtl/nes_pad_responder_if.sv
// Console-side bundle of the pad responder: control, strobes and serial output.
// Latency: n/a (wiring only).
// Backpressure: none; the console strobes are free-running and never stalled.
// Ports: en, buttons[7:0], latch_in, pulse_in into the responder;
//        data_out, bit_idx[3:0], frame_done, frame_cnt[15:0] out of it.
interface nes_pad_responder_if;
  logic        en;
  logic [7:0]  buttons;
  logic        latch_in;
  logic        pulse_in;
  logic        data_out;
  logic [3:0]  bit_idx;
  logic        frame_done;
  logic [15:0] frame_cnt;

  // Console / bench side.
  modport master (
    output en, buttons, latch_in, pulse_in,
    input  data_out, bit_idx, frame_done, frame_cnt
  );

  // Responder side.
  modport slave (
    input  en, buttons, latch_in, pulse_in,
    output data_out, bit_idx, frame_done, frame_cnt
  );
endinterface

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe plus rising-edge detect.
// Latency: o_level follows i_async after SYNC_STAGES clk edges; o_rise is combinational on o_level.
// Backpressure: none; every input transition is passed through.
// Ports: clk, reset (async, active-high), i_async (raw strobe),
//        o_level (synchronized level), o_rise (one-cycle rising-edge pulse).
module nes_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_level_d;

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller emulation: answers console latch/pulse strobes with serial, active-low button data.
// Latency: data_out reflects a pulse_in rise SYNC_STAGES+1 clk cycles later; data_out is registered.
// Backpressure: none; console pulses must be spaced at least 4x the latency apart.
// Ports: clk, reset (async, active-high); bus (slave modport): en, buttons, latch_in, pulse_in in;
//        data_out, bit_idx, frame_done, frame_cnt out.
module nes_pad_responder #(
  parameter int   SYNC_STAGES = 2,    // legal range 2..4
  parameter logic TRAIL_BIT   = 1'b1  // level driven after the last bit
) (
  input  logic                clk,
  input  logic                reset,
  nes_pad_responder_if.slave  bus
);
  import nes_pkg::*;

  localparam logic [3:0] LAST_IDX  = 4'(NES_BITS - 1);
  localparam logic [3:0] TRAIL_IDX = 4'(NES_BITS);

  logic                w_latch_lvl;
  logic                w_latch_rise;
  logic                w_pulse_lvl_unused;
  logic                w_pulse_rise;
  logic [NES_BITS-1:0] w_shreg_next;

  nes_state_e          r_state;
  logic [NES_BITS-1:0] r_shreg;
  logic                r_data_out;
  logic [3:0]          r_bit_idx;
  logic                r_frame_done;
  logic [15:0]         r_frame_cnt;

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.latch_in),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise)
  );

  // Only the edge of the shift clock matters; its level is not consumed.
  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.pulse_in),
    .o_level (w_pulse_lvl_unused),
    .o_rise  (w_pulse_rise)
  );

  // Bit 0 is always the one on the wire; zeros fill from the top.
  assign w_shreg_next = r_shreg >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_data_out   <= 1'b1;
      r_bit_idx    <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (!bus.en) begin
        // Disabled: park idle with the line released; the frame count is kept.
        r_state    <= ST_IDLE;
        r_data_out <= 1'b1;
        r_bit_idx  <= '0;
      end else if (w_latch_rise) begin
        // A latch always restarts the frame, even mid-shift; a same-cycle pulse is dropped.
        r_state    <= ST_LOAD;
        r_shreg    <= bus.buttons;
        r_data_out <= ~bus.buttons[BTN_A];
        r_bit_idx  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_data_out <= 1'b1;
            r_bit_idx  <= '0;
          end
          ST_LOAD: begin
            if (w_latch_lvl) begin
              // Transparent while latched: button A follows the live input.
              r_shreg    <= bus.buttons;
              r_data_out <= ~bus.buttons[BTN_A];
            end else begin
              r_state   <= ST_SHIFT;
              r_bit_idx <= '0;
            end
          end
          ST_SHIFT: begin
            if (w_pulse_rise) begin
              r_shreg <= w_shreg_next;
              if (r_bit_idx == LAST_IDX) begin
                r_state      <= ST_TRAIL;
                r_bit_idx    <= TRAIL_IDX;
                r_data_out   <= TRAIL_BIT;
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
              end else begin
                r_bit_idx  <= r_bit_idx + 4'd1;
                r_data_out <= ~w_shreg_next[0];
              end
            end
          end
          ST_TRAIL: begin
            r_bit_idx  <= TRAIL_IDX;
            r_data_out <= TRAIL_BIT;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.bit_idx    = r_bit_idx;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_cnt  = r_frame_cnt;

endmodule
